// File: rtl/m_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// instruction field codes, ALU codes, mux encodings and the control word.
package m_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_WB_R     = 4'd3,
        S_JR       = 4'd4,
        S_EX_I     = 4'd5,
        S_WB_I     = 4'd6,
        S_LUI      = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_WB_LW    = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BR       = 4'd12,
        S_JMP      = 4'd13,
        S_JAL      = 4'd14,
        S_ILL      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4, ALU_SRL = 4'd5, ALU_SUB = 4'd6, ALU_SLT = 4'd7;

    localparam logic [1:0] REG_DST_RT = 2'b00, REG_DST_RD = 2'b01, REG_DST_RA = 2'b10;
    localparam logic [1:0] MTR_ALUOUT = 2'b00, MTR_MDR = 2'b01, MTR_LUI = 2'b10, MTR_PC = 2'b11;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_word_t;

    // True for the R-type funct codes executed through EX_R/WB_R.
    function automatic logic funct_is_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/m_ctrl_decode.sv
// State-to-control-word lookup. Pure combinational; only IF and JAL look at
// MIO_ready, and only EX_R/EX_I/BR look at the instruction fields.
module m_ctrl_decode
    import m_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mio_ready,
    output ctrl_word_t ctrl
);

    // Control word for the current state; unlisted fields stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mio_ready;
                ctrl.pc_write  = mio_ready;
            end
            S_ID: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = funct_to_alu(funct);
            end
            S_WB_R: begin
                ctrl.reg_dst   = REG_DST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_JR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_XORI: ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_WB_I:  ctrl.reg_write = 1'b1;
            S_LUI: begin
                ctrl.mem_to_reg = MTR_LUI;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_WB_LW: begin
                ctrl.mem_to_reg = MTR_MDR;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.branch        = (opcode == OP_BEQ);
            end
            S_JMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_JAL: begin
                // The link write must coincide with the cycle the PC update lands.
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = MTR_PC;
                ctrl.reg_write  = mio_ready;
            end
            S_ILL:   ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/m_ctrl_fsm.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic,
// drives every datapath control input through the state decoder.
module m_ctrl_fsm
    import m_ctrl_pkg::*;
#(
    parameter int ALU_W   = 4,
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        Inst,
    input  logic               zero,
    input  logic               MIO_ready,
    output logic               IorD,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               Branch,
    output logic [ALU_W-1:0]   ALU_operation,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               illegal_inst,
    output logic [STATE_W-1:0] state
);

    state_t     state_r;
    ctrl_word_t ctrl_s;
    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic       unused_s;

    assign opcode_s = Inst[31:26];
    assign funct_s  = Inst[5:0];
    // The branch decision is taken in the datapath from PCWriteCond/Branch/zero.
    assign unused_s = ^{zero, Inst[25:6]};

    // State register and next-state logic; memory-facing states wait for MIO_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IF;
        end else begin
            case (state_r)
                S_IF:     state_r <= MIO_ready ? S_ID : S_IF;
                S_ID: begin
                    case (opcode_s)
                        OP_RTYPE: begin
                            if (funct_s == FN_JR)
                                state_r <= S_JR;
                            else if (funct_is_alu(funct_s))
                                state_r <= S_EX_R;
                            else
                                state_r <= S_ILL;
                        end
                        OP_J:                                        state_r <= S_JMP;
                        OP_JAL:                                      state_r <= S_JAL;
                        OP_BEQ, OP_BNE:                              state_r <= S_BR;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_r <= S_EX_I;
                        OP_LUI:                                      state_r <= S_LUI;
                        OP_LW, OP_SW:                                state_r <= S_MEM_ADDR;
                        default:                                     state_r <= S_ILL;
                    endcase
                end
                S_EX_R:     state_r <= S_WB_R;
                S_EX_I:     state_r <= S_WB_I;
                S_MEM_ADDR: state_r <= (opcode_s == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_r <= MIO_ready ? S_WB_LW : S_MEM_RD;
                S_MEM_WR:   state_r <= MIO_ready ? S_IF : S_MEM_WR;
                S_JR:       state_r <= MIO_ready ? S_IF : S_JR;
                S_BR:       state_r <= MIO_ready ? S_IF : S_BR;
                S_JMP:      state_r <= MIO_ready ? S_IF : S_JMP;
                S_JAL:      state_r <= MIO_ready ? S_IF : S_JAL;
                default:    state_r <= S_IF;
            endcase
        end
    end

    m_ctrl_decode u_decode (
        .state     (state_r),
        .opcode    (opcode_s),
        .funct     (funct_s),
        .mio_ready (MIO_ready),
        .ctrl      (ctrl_s)
    );

    assign IorD          = ctrl_s.iord;
    assign IRWrite       = ctrl_s.ir_write;
    assign RegDst        = ctrl_s.reg_dst;
    assign RegWrite      = ctrl_s.reg_write;
    assign MemtoReg      = ctrl_s.mem_to_reg;
    assign ALUSrcA       = ctrl_s.alu_src_a;
    assign ALUSrcB       = ctrl_s.alu_src_b;
    assign PCSource      = ctrl_s.pc_source;
    assign PCWrite       = ctrl_s.pc_write;
    assign PCWriteCond   = ctrl_s.pc_write_cond;
    assign Branch        = ctrl_s.branch;
    assign ALU_operation = ALU_W'(ctrl_s.alu_op);
    assign MemRead       = ctrl_s.mem_read;
    assign MemWrite      = ctrl_s.mem_write;
    assign illegal_inst  = ctrl_s.illegal;
    assign state         = STATE_W'(state_r);

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Bench for m_ctrl_fsm: directed vector table, hand-written corner sequences and
// a randomized instruction stream checked against an instruction-level model.
module tb_m_ctrl_fsm;
    import m_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Inst = 32'h0;
    logic        zero = 1'b0;
    logic        MIO_ready = 1'b0;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
    logic        MemRead, MemWrite, illegal_inst;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [3:0]  ALU_operation, state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    m_ctrl_fsm dut (
        .clock(clock), .reset(reset), .Inst(Inst), .zero(zero), .MIO_ready(MIO_ready),
        .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal_inst(illegal_inst), .state(state)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic ctrl_word_t dut_ctrl();
        ctrl_word_t c;
        c.iord = IorD; c.ir_write = IRWrite; c.reg_dst = RegDst; c.reg_write = RegWrite;
        c.mem_to_reg = MemtoReg; c.alu_src_a = ALUSrcA; c.alu_src_b = ALUSrcB;
        c.pc_source = PCSource; c.pc_write = PCWrite; c.pc_write_cond = PCWriteCond;
        c.branch = Branch; c.alu_op = ALU_operation; c.mem_read = MemRead;
        c.mem_write = MemWrite; c.illegal = illegal_inst;
        return c;
    endfunction

    // Expected control outputs for one step of an instruction, straight from the step table.
    function automatic ctrl_word_t model_ctrl(state_t s, logic [31:0] inst, logic mio);
        ctrl_word_t c = '0;
        logic [5:0] op = inst[31:26];
        logic [5:0] fn = inst[5:0];
        case (s)
            S_IF:   begin c.mem_read = 1; c.alu_src_b = 2'd1; c.alu_op = 4'd2;
                          c.ir_write = mio; c.pc_write = mio; end
            S_ID:   begin c.alu_src_b = 2'd3; c.alu_op = 4'd2; end
            S_EX_R: begin
                c.alu_src_a = 1;
                case (fn)
                    6'h20: c.alu_op = 4'd2;  6'h22: c.alu_op = 4'd6;
                    6'h24: c.alu_op = 4'd0;  6'h25: c.alu_op = 4'd1;
                    6'h26: c.alu_op = 4'd3;  6'h27: c.alu_op = 4'd4;
                    6'h2A: c.alu_op = 4'd7;  6'h02: c.alu_op = 4'd5;
                    default: c.alu_op = 4'hF;
                endcase
            end
            S_WB_R: begin c.reg_dst = 2'd1; c.reg_write = 1; end
            S_JR:   begin c.alu_src_a = 1; c.alu_op = 4'd2; c.pc_write = 1; end
            S_EX_I: begin
                c.alu_src_a = 1; c.alu_src_b = 2'd2;
                case (op)
                    6'h08: c.alu_op = 4'd2;  6'h0A: c.alu_op = 4'd7;
                    6'h0C: c.alu_op = 4'd0;  6'h0D: c.alu_op = 4'd1;
                    6'h0E: c.alu_op = 4'd3;
                    default: c.alu_op = 4'hF;
                endcase
            end
            S_WB_I:     c.reg_write = 1;
            S_LUI:      begin c.mem_to_reg = 2'd2; c.reg_write = 1; end
            S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = 4'd2; end
            S_MEM_RD:   begin c.iord = 1; c.mem_read = 1; end
            S_WB_LW:    begin c.mem_to_reg = 2'd1; c.reg_write = 1; end
            S_MEM_WR:   begin c.iord = 1; c.mem_write = 1; end
            S_BR:   begin c.alu_src_a = 1; c.alu_op = 4'd6; c.pc_source = 2'd1;
                          c.pc_write_cond = 1; c.branch = (op == 6'h04); end
            S_JMP:  begin c.pc_source = 2'd2; c.pc_write = 1; end
            S_JAL:  begin c.pc_source = 2'd2; c.pc_write = 1; c.reg_dst = 2'd2;
                          c.mem_to_reg = 2'd3; c.reg_write = mio; end
            default: c.illegal = 1;
        endcase
        return c;
    endfunction

    // Instruction-level model: the ordered list of steps an instruction walks through.
    state_t plan_q[$];
    function automatic void build_plan(logic [31:0] inst);
        logic [5:0] op = inst[31:26];
        logic [5:0] fn = inst[5:0];
        plan_q.delete();
        plan_q.push_back(S_IF);
        plan_q.push_back(S_ID);
        if (op == 6'h00 && fn == 6'h08)                            plan_q.push_back(S_JR);
        else if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02}) begin
            plan_q.push_back(S_EX_R); plan_q.push_back(S_WB_R);
        end
        else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E}) begin
            plan_q.push_back(S_EX_I); plan_q.push_back(S_WB_I);
        end
        else if (op == 6'h0F) plan_q.push_back(S_LUI);
        else if (op == 6'h23) begin
            plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_RD); plan_q.push_back(S_WB_LW);
        end
        else if (op == 6'h2B) begin
            plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_WR);
        end
        else if (op == 6'h04 || op == 6'h05) plan_q.push_back(S_BR);
        else if (op == 6'h02)                plan_q.push_back(S_JMP);
        else if (op == 6'h03)                plan_q.push_back(S_JAL);
        else                                 plan_q.push_back(S_ILL);
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        mio;
        state_t      st;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic [31:0] i, logic m, state_t s);
        vec_t v;
        v.inst = i; v.mio = m; v.st = s;
        tbl.push_back(v);
    endfunction

    task automatic cyc(input logic [31:0] i, input logic m);
        @(negedge clock);
        Inst = i;
        MIO_ready = m;
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'h20010005, I_LW  = 32'h8C220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003, I_BNE = 32'h14220003;
    localparam logic [31:0] I_JAL  = 32'h0C000010, I_BAD = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h0000003F, I_ADD = 32'h00221820;
    localparam logic [31:0] I_SW   = 32'hAC220004;

    logic [5:0] op_list [13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                                 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
    logic [5:0] fn_list [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom();
        case ($urandom_range(0, 5))
            0:       begin r[31:26] = 6'h00; r[5:0] = fn_list[$urandom_range(0, 8)]; end
            5:       r = r;
            default: r[31:26] = op_list[$urandom_range(0, 12)];
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] cur_inst;
        int          idx;

        // Reset state: IF decode while reset is held.
        MIO_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_state", 32'(state), 32'(S_IF));
        chk("reset_ctrl", 32'(dut_ctrl()), 32'(model_ctrl(S_IF, 32'h0, 1'b0)));
        MIO_ready = 1'b1;
        #1;
        chk("reset_irwrite", 32'(IRWrite), 32'd1);
        MIO_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Directed table.
        add(I_ADDI, 1, S_IF); add(I_ADDI, 1, S_ID); add(I_ADDI, 1, S_EX_I); add(I_ADDI, 1, S_WB_I);
        add(I_LW, 1, S_IF); add(I_LW, 1, S_ID); add(I_LW, 1, S_MEM_ADDR);
        add(I_LW, 0, S_MEM_RD); add(I_LW, 0, S_MEM_RD); add(I_LW, 0, S_MEM_RD);
        add(I_LW, 1, S_MEM_RD); add(I_LW, 1, S_WB_LW);
        add(I_BEQ, 1, S_IF); add(I_BEQ, 1, S_ID); add(I_BEQ, 1, S_BR);
        add(I_BNE, 1, S_IF); add(I_BNE, 1, S_ID); add(I_BNE, 1, S_BR);
        add(I_JAL, 1, S_IF); add(I_JAL, 1, S_ID); add(I_JAL, 1, S_JAL);
        add(I_BAD, 1, S_IF); add(I_BAD, 1, S_ID); add(I_BAD, 1, S_ILL);
        add(I_BADF, 1, S_IF); add(I_BADF, 1, S_ID); add(I_BADF, 1, S_ILL);
        add(I_ADD, 0, S_IF); add(I_ADD, 1, S_IF); add(I_ADD, 1, S_ID);
        add(I_ADD, 1, S_EX_R); add(I_ADD, 1, S_WB_R);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].inst, tbl[i].mio);
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_ctrl", i), 32'(dut_ctrl()),
                32'(model_ctrl(tbl[i].st, tbl[i].inst, tbl[i].mio)));
        end

        // addi walk with literal write-back fields.
        cyc(I_ADDI, 1); cyc(I_ADDI, 1); cyc(I_ADDI, 1);
        chk("addi_exi_alu", 32'(ALU_operation), 32'd2);
        cyc(I_ADDI, 1);
        chk("addi_wbi_state", 32'(state), 32'(S_WB_I));
        chk("addi_wbi_regwrite", 32'(RegWrite), 32'd1);
        chk("addi_wbi_regdst", 32'(RegDst), 32'd0);
        chk("addi_wbi_memtoreg", 32'(MemtoReg), 32'd0);

        // Branches.
        cyc(I_BEQ, 1); cyc(I_BEQ, 1); cyc(I_BEQ, 1);
        chk("beq_alu", 32'(ALU_operation), 32'd6);
        chk("beq_pcsource", 32'(PCSource), 32'd1);
        chk("beq_pcwc", 32'(PCWriteCond), 32'd1);
        chk("beq_branch", 32'(Branch), 32'd1);
        cyc(I_BNE, 1); cyc(I_BNE, 1); cyc(I_BNE, 1);
        chk("bne_alu", 32'(ALU_operation), 32'd6);
        chk("bne_branch", 32'(Branch), 32'd0);

        // JAL: stall first, link write only with MIO_ready.
        cyc(I_JAL, 1); cyc(I_JAL, 1); cyc(I_JAL, 0);
        chk("jal_stall_regwrite", 32'(RegWrite), 32'd0);
        chk("jal_stall_pcwrite", 32'(PCWrite), 32'd1);
        cyc(I_JAL, 1);
        chk("jal_state", 32'(state), 32'(S_JAL));
        chk("jal_fields", {RegDst, MemtoReg, RegWrite, PCWrite, PCSource},
            {2'b10, 2'b11, 1'b1, 1'b1, 2'b10});

        // Illegal opcode pulses for exactly one cycle.
        cyc(I_BAD, 1); cyc(I_BAD, 1); cyc(I_BAD, 0);
        chk("ill_pulse", 32'(illegal_inst), 32'd1);
        chk("ill_nowrite", {RegWrite, MemWrite, PCWrite}, 3'b000);
        cyc(I_BAD, 0);
        chk("ill_next_state", 32'(state), 32'(S_IF));
        chk("ill_pulse_end", 32'(illegal_inst), 32'd0);

        // Reset during a stalled store.
        cyc(I_SW, 1); cyc(I_SW, 1); cyc(I_SW, 1); cyc(I_SW, 0);
        chk("sw_memwrite", 32'(MemWrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_state", 32'(state), 32'(S_IF));
        chk("rst_mid_memwrite", 32'(MemWrite), 32'd0);
        cyc(I_ADDI, 1);
        reset = 1'b1;
        #1;
        chk("rst_release_state", 32'(state), 32'(S_IF));
        cyc(I_ADDI, 1);
        chk("rst_refetch_state", 32'(state), 32'(S_ID));
        cyc(I_ADDI, 1); cyc(I_ADDI, 1);

        // Randomized stream against the instruction-level model, starting in IF.
        cur_inst = rand_inst();
        build_plan(cur_inst);
        idx = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            Inst = cur_inst;
            MIO_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_state", 32'(state), 32'(plan_q[idx]));
            chk("rnd_ctrl", 32'(dut_ctrl()), 32'(model_ctrl(plan_q[idx], cur_inst, MIO_ready)));
            if (!(plan_q[idx] inside {S_IF, S_JR, S_MEM_RD, S_MEM_WR, S_BR, S_JMP, S_JAL})
                || MIO_ready) begin
                idx++;
                if (idx == plan_q.size()) begin
                    cur_inst = rand_inst();
                    build_plan(cur_inst);
                    idx = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
